// File: rtl/backprop_pool_seq.sv
// Sequencer for 2x2 average-pool backprop: reads each pooled gradient, scales by 1/4, writes 4 copies.
// Optional macro BACKPROP_POOL_SIGNED_EN selects signed divide-toward-zero scaling.
module backprop_pool_seq #(
   parameter int WIDTH_IN  = 4,
   parameter int WIDTH_OUT = WIDTH_IN * 2,
   parameter int AIN_W     = $clog2(WIDTH_IN * WIDTH_IN),
   parameter int AOUT_W    = $clog2(WIDTH_OUT * WIDTH_OUT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [AIN_W-1:0]  rd_addr,
   input  logic [15:0]       rd_data,
   output logic              wr_en,
   output logic [AOUT_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   input  logic              wr_ready
);

   localparam int CW = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH_IN - 1);

   typedef enum logic [2:0] {IDLE, READ, WAIT, WR0, WR1, WR2, WR3, DONE} state_t;

   state_t        state, next;
   logic [CW-1:0] i, j;
   logic [15:0]   hold, q;
   logic          last, writing;
   int unsigned   base, off;

   assign last    = (i == LAST) && (j == LAST);
   assign writing = (state == WR0) || (state == WR1) || (state == WR2) || (state == WR3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
         hold  <= '0;
      end else begin
         state <= next;
         if (state == WAIT) hold <= rd_data;
         if (state == DONE) begin
            i <= '0;
            j <= '0;
         end else if (state == WR3 && wr_ready && !last) begin
            if (i == LAST) begin
               i <= '0;
               j <= j + 1'b1;
            end else begin
               i <= i + 1'b1;
            end
         end
      end
   end

   // Signed mode biases negatives by 3 so the arithmetic shift truncates toward zero.
   always_comb begin
      q = '0;
`ifdef BACKPROP_POOL_SIGNED_EN
      begin
         logic [15:0] adj;
         adj = hold + {14'b0, hold[15], hold[15]};
         q   = {{2{adj[15]}}, adj[15:2]};
      end
`else
      q = {2'b00, hold[15:2]};
`endif
   end

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (start) next = READ;
         READ:    next = WAIT;
         WAIT:    next = WR0;
         WR0:     if (wr_ready) next = WR1;
         WR1:     if (wr_ready) next = WR2;
         WR2:     if (wr_ready) next = WR3;
         WR3:     if (wr_ready) next = last ? DONE : READ;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      base = 2 * i + 2 * j * WIDTH_OUT;
      off  = 0;
      case (state)
         WR1:     off = 1;
         WR2:     off = WIDTH_OUT;
         WR3:     off = WIDTH_OUT + 1;
         default: off = 0;
      endcase
      busy    = (state != IDLE) && (state != DONE);
      done    = (state == DONE);
      rd_en   = (state == READ);
      rd_addr = rd_en ? AIN_W'(i + j * WIDTH_IN) : '0;
      wr_en   = writing;
      wr_addr = writing ? AOUT_W'(base + off) : '0;
      wr_data = writing ? q : '0;
   end

endmodule

// File: tb/tb_backprop_pool_seq.sv
// Directed self-checking bench for backprop_pool_seq (WIDTH_IN=4) with a memory model and scoreboard.
module tb_backprop_pool_seq;
   localparam int LOGN = 1024;

   logic        clk, rst_n, start, busy, done, rd_en, wr_en, wr_ready;
   logic [3:0]  rd_addr;
   logic [5:0]  wr_addr;
   logic [15:0] rd_data, wr_data;

   logic [15:0] in_mem  [0:15];
   logic [15:0] out_mem [0:63];
   int          wr_cnt  [0:63];
   int          overlap;
   logic        sb_clr;

   logic        lg_busy [0:LOGN-1], lg_done [0:LOGN-1], lg_rd_en [0:LOGN-1], lg_wr_en [0:LOGN-1];
   logic [3:0]  lg_rd_addr [0:LOGN-1];
   logic [5:0]  lg_wr_addr [0:LOGN-1];
   logic [15:0] lg_wr_data [0:LOGN-1];

   int checks = 0;
   int passes = 0;

   backprop_pool_seq #(.WIDTH_IN(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= in_mem[rd_addr];
      if (sb_clr) begin
         for (int a = 0; a < 64; a++) wr_cnt[a] <= 0;
         overlap <= 0;
      end else begin
         if (wr_en && wr_ready) begin
            out_mem[wr_addr] <= wr_data;
            wr_cnt[wr_addr]  <= wr_cnt[wr_addr] + 1;
         end
         if (rd_en && wr_en) overlap <= overlap + 1;
      end
   end

   function automatic logic [15:0] scale(input logic [15:0] v);
`ifdef BACKPROP_POOL_SIGNED_EN
      int s;
      s = $signed(v) / 4;
      return 16'(s);
`else
      return v / 16'd4;
`endif
   endfunction

   function automatic logic [15:0] exp_word(input int a);
      int ii, jj;
      ii = (a % 8) / 2;
      jj = a / 16;
      return scale(in_mem[ii + 4 * jj]);
   endfunction

   // mode 0: wr_ready=1, 1: random, 2: wr_ready=0 for cycles 5..9
   task automatic run_pass(input int mode, input int s2, input int s3, input int rst_cyc,
                           output int dcyc, output int ndone);
      bit fin;
      sb_clr = 1'b1;
      @(posedge clk); #1 sb_clr = 1'b0;
      dcyc = -1; ndone = 0; fin = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n < LOGN && !fin; n++) begin
         if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
         else wr_ready = !(mode == 2 && n >= 5 && n <= 9);
         start = (n == s2) || (n == s3);
         rst_n = (n != rst_cyc);
         @(negedge clk);
         lg_busy[n] = busy; lg_done[n] = done; lg_rd_en[n] = rd_en; lg_wr_en[n] = wr_en;
         lg_rd_addr[n] = rd_addr; lg_wr_addr[n] = wr_addr; lg_wr_data[n] = wr_data;
         if (done) begin
            ndone++;
            if (dcyc < 0) dcyc = n;
         end
         if (rst_cyc > 0 && n == rst_cyc + 1) fin = 1;
         if (rst_cyc == 0 && dcyc > 0 && n >= dcyc + 4) fin = 1;
         @(posedge clk); #1;
      end
      start = 1'b0; rst_n = 1'b1; wr_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1; sb_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b want 00", busy, done); else passes++;
      checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) $display("FAIL reset_strobes got %b%b want 00", rd_en, wr_en); else passes++;
      checks++; if (rd_addr !== 4'd0 || wr_addr !== 6'd0 || wr_data !== 16'd0)
         $display("FAIL reset_buses got %h %h %h want 0 0 0", rd_addr, wr_addr, wr_data); else passes++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_pass;
      int d, nd, bcnt, bad;
      for (int k = 0; k < 16; k++) in_mem[k] = 16'(k * 4);
      run_pass(0, 0, 0, 0, d, nd);
      checks++; if (d !== 97) $display("FAIL full_done_cycle got %0d want 97", d); else passes++;
      checks++; if (nd !== 1) $display("FAIL full_done_count got %0d want 1", nd); else passes++;
      bcnt = 0;
      for (int n = 1; n <= 100; n++) if (lg_busy[n]) bcnt++;
      checks++; if (lg_busy[1] !== 1'b1 || lg_busy[96] !== 1'b1 || lg_busy[97] !== 1'b0 || bcnt !== 96)
         $display("FAIL full_busy_window got %b%b%b cnt %0d want 110 cnt 96", lg_busy[1], lg_busy[96], lg_busy[97], bcnt); else passes++;
      checks++; if (lg_rd_en[1] !== 1'b1 || lg_rd_en[7] !== 1'b1 || lg_rd_addr[7] !== 4'd1)
         $display("FAIL full_read_seq got %b%b addr %0d want 11 addr 1", lg_rd_en[1], lg_rd_en[7], lg_rd_addr[7]); else passes++;
      checks++; if (lg_wr_addr[3] !== 6'd0 || lg_wr_addr[4] !== 6'd1 || lg_wr_addr[5] !== 6'd8 || lg_wr_addr[6] !== 6'd9)
         $display("FAIL full_beat_addr got %0d %0d %0d %0d want 0 1 8 9", lg_wr_addr[3], lg_wr_addr[4], lg_wr_addr[5], lg_wr_addr[6]); else passes++;
      checks++; if (out_mem[43] !== 16'd9) $display("FAIL full_elem_1_2 got %h want 0009", out_mem[43]); else passes++;
      bad = 0;
      for (int a = 0; a < 64; a++) if (wr_cnt[a] !== 1 || out_mem[a] !== 16'((a % 8) / 2 + 4 * (a / 16))) bad++;
      checks++; if (bad !== 0) $display("FAIL full_scoreboard got %0d bad addresses want 0", bad); else passes++;
      checks++; if (overlap !== 0) $display("FAIL full_rd_wr_overlap got %0d want 0", overlap); else passes++;
   endtask

   task automatic test_scaling;
      int d, nd, bad;
      for (int k = 0; k < 16; k++) in_mem[k] = 16'h8001 + 16'(k * 16'h0123);
      in_mem[0] = 16'h0007; in_mem[1] = 16'hFFF9; in_mem[2] = 16'hFFFC;
      run_pass(0, 0, 0, 0, d, nd);
      checks++; if (out_mem[0] !== 16'h0001 || out_mem[9] !== 16'h0001)
         $display("FAIL scale_0007 got %h %h want 0001 0001", out_mem[0], out_mem[9]); else passes++;
`ifdef BACKPROP_POOL_SIGNED_EN
      checks++; if (out_mem[2] !== 16'hFFFF) $display("FAIL scale_fff9 got %h want ffff", out_mem[2]); else passes++;
      checks++; if (out_mem[4] !== 16'hFFFF) $display("FAIL scale_fffc got %h want ffff", out_mem[4]); else passes++;
`else
      checks++; if (out_mem[2] !== 16'h3FFE) $display("FAIL scale_fff9 got %h want 3ffe", out_mem[2]); else passes++;
      checks++; if (out_mem[4] !== 16'h3FFF) $display("FAIL scale_fffc got %h want 3fff", out_mem[4]); else passes++;
`endif
      bad = 0;
      for (int a = 0; a < 64; a++) if (wr_cnt[a] !== 1 || out_mem[a] !== exp_word(a)) bad++;
      checks++; if (bad !== 0 || d !== 97) $display("FAIL scale_scoreboard got %0d bad done %0d want 0 done 97", bad, d); else passes++;
   endtask

   task automatic test_stall;
      int d, nd, bad;
      for (int k = 0; k < 16; k++) in_mem[k] = 16'(k * 4);
      in_mem[0] = 16'h0044;
      run_pass(2, 0, 0, 0, d, nd);
      checks++; if (d !== 102) $display("FAIL stall_done_cycle got %0d want 102", d); else passes++;
      bad = 0;
      for (int n = 5; n <= 10; n++) if (lg_wr_en[n] !== 1'b1 || lg_wr_addr[n] !== 6'd8 || lg_wr_data[n] !== 16'h0011) bad++;
      checks++; if (bad !== 0) $display("FAIL stall_hold got %0d unstable cycles want 0", bad); else passes++;
      checks++; if (lg_wr_addr[11] !== 6'd9) $display("FAIL stall_resume_addr got %0d want 9", lg_wr_addr[11]); else passes++;
      bad = 0;
      for (int a = 0; a < 64; a++) if (wr_cnt[a] !== 1 || out_mem[a] !== exp_word(a)) bad++;
      checks++; if (bad !== 0) $display("FAIL stall_scoreboard got %0d bad addresses want 0", bad); else passes++;
   endtask

   task automatic test_start_ignored;
      int d, nd, tot;
      for (int k = 0; k < 16; k++) in_mem[k] = 16'(k * 4 + 100);
      run_pass(0, 20, 97, 0, d, nd);
      checks++; if (d !== 97 || nd !== 1) $display("FAIL restart_done got cycle %0d count %0d want 97 1", d, nd); else passes++;
      checks++; if (lg_busy[98] !== 1'b0 || lg_busy[99] !== 1'b0 || lg_busy[100] !== 1'b0)
         $display("FAIL restart_idle got %b%b%b want 000", lg_busy[98], lg_busy[99], lg_busy[100]); else passes++;
      tot = 0;
      for (int a = 0; a < 64; a++) tot += wr_cnt[a];
      checks++; if (tot !== 64) $display("FAIL restart_writes got %0d want 64", tot); else passes++;
   endtask

   task automatic test_mid_reset;
      int d, nd, bad;
      for (int k = 0; k < 16; k++) in_mem[k] = 16'(k * 8 + 3);
      run_pass(0, 0, 0, 40, d, nd);
      checks++; if (d !== -1) $display("FAIL midrst_no_done got %0d want -1", d); else passes++;
      checks++; if ({lg_busy[41], lg_done[41], lg_rd_en[41], lg_wr_en[41]} !== 4'b0000 ||
                    lg_rd_addr[41] !== 4'd0 || lg_wr_addr[41] !== 6'd0 || lg_wr_data[41] !== 16'd0)
         $display("FAIL midrst_outputs got %b%b%b%b %h %h %h want all 0", lg_busy[41], lg_done[41], lg_rd_en[41],
                  lg_wr_en[41], lg_rd_addr[41], lg_wr_addr[41], lg_wr_data[41]); else passes++;
      for (int k = 0; k < 16; k++) in_mem[k] = 16'(16'hF000 + k * 40);
      run_pass(0, 0, 0, 0, d, nd);
      checks++; if (d !== 97) $display("FAIL midrst_rerun_done got %0d want 97", d); else passes++;
      bad = 0;
      for (int a = 0; a < 64; a++) if (wr_cnt[a] !== 1 || out_mem[a] !== exp_word(a)) bad++;
      checks++; if (bad !== 0) $display("FAIL midrst_scoreboard got %0d bad addresses want 0", bad); else passes++;
   endtask

   task automatic test_random;
      int d, nd, bad;
      for (int p = 0; p < 200; p++) begin
         for (int k = 0; k < 16; k++) in_mem[k] = 16'($urandom);
         run_pass(1, 0, 0, 0, d, nd);
         bad = 0;
         for (int a = 0; a < 64; a++) if (wr_cnt[a] !== 1 || out_mem[a] !== exp_word(a)) bad++;
         checks++;
         if (d < 0 || nd !== 1 || bad !== 0 || overlap !== 0)
            $display("FAIL random_pass_%0d got done %0d count %0d bad %0d overlap %0d want done>0 1 0 0", p, d, nd, bad, overlap);
         else passes++;
      end
   endtask

   initial begin
      test_reset;
      test_full_pass;
      test_scaling;
      test_stall;
      test_start_ignored;
      test_mid_reset;
      test_random;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
